// File: rtl/paj7620_seq.sv
// PAJ7620 init/poll sequencer: wake write, config-table stream, periodic gesture read.
// Optional NACK retry enabled by defining PAJ7620_RETRY_EN.
module paj7620_seq #(
    parameter int unsigned CFG_NUM   = 51,
    parameter int unsigned WAKE_DLY  = 1000,
    parameter int unsigned POLL_DLY  = 10000,
    parameter logic [7:0]  GES_REG   = 8'h43,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic        i2c_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        i2c_end,
    input  logic        i2c_nack,
    input  logic [7:0]  rd_data,
    input  logic [15:0] cfg_data,
    output logic [5:0]  cfg_idx,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic [7:0]  byte_addr,
    output logic [7:0]  wr_data,
    output logic        init_done,
    output logic [7:0]  gesture,
    output logic        gesture_vld,
    output logic        err
);

    localparam int unsigned DLY_MAX = (WAKE_DLY > POLL_DLY) ? WAKE_DLY : POLL_DLY;
    localparam int unsigned CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int unsigned IDX_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE_WAIT,
        S_WAKE_DLY,
        S_CFG_ISSUE,
        S_CFG_WAIT,
        S_POLL_DLY,
        S_RD_WAIT,
        S_ERR
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   cfg_idx_d;
    logic               i2c_start_d, wr_en_d, rd_en_d;
    logic [7:0]         byte_addr_d, wr_data_d;
    logic               init_done_d;
    logic [7:0]         gesture_d;
    logic               gesture_vld_d, err_d;

`ifdef PAJ7620_RETRY_EN
    localparam int unsigned RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RTY_W-1:0]   rty_cnt, rty_cnt_d;
`endif

    // Next-state and next-output logic; every register is loaded from its _d value
    always_comb begin
        state_d       = state;
        cnt_d         = '0;
        cfg_idx_d     = cfg_idx;
        i2c_start_d   = 1'b0;
        wr_en_d       = wr_en;
        rd_en_d       = rd_en;
        byte_addr_d   = byte_addr;
        wr_data_d     = wr_data;
        init_done_d   = init_done;
        gesture_d     = gesture;
        gesture_vld_d = 1'b0;
        err_d         = err;
`ifdef PAJ7620_RETRY_EN
        rty_cnt_d     = rty_cnt;
`endif

        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d     = S_WAKE_WAIT;
                    i2c_start_d = 1'b1;
                    wr_en_d     = 1'b1;
                    rd_en_d     = 1'b0;
                    byte_addr_d = 8'h00;
                    wr_data_d   = 8'h00;
                    err_d       = 1'b0;
                    init_done_d = 1'b0;
                    cfg_idx_d   = '0;
`ifdef PAJ7620_RETRY_EN
                    rty_cnt_d   = '0;
`endif
                end
            end

            // The sensor NACKs the wake access while asleep, so status is ignored
            S_WAKE_WAIT: begin
                if (i2c_end) begin
                    state_d = S_WAKE_DLY;
                end
            end

            S_WAKE_DLY: begin
                if (cnt == CNT_W'(WAKE_DLY - 1)) begin
                    state_d   = S_CFG_ISSUE;
                    cfg_idx_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            S_CFG_ISSUE: begin
                state_d     = S_CFG_WAIT;
                i2c_start_d = 1'b1;
                wr_en_d     = 1'b1;
                rd_en_d     = 1'b0;
                byte_addr_d = cfg_data[15:8];
                wr_data_d   = cfg_data[7:0];
            end

            S_CFG_WAIT: begin
                if (i2c_end) begin
                    if (!i2c_nack) begin
`ifdef PAJ7620_RETRY_EN
                        rty_cnt_d = '0;
`endif
                        if (cfg_idx == IDX_W'(CFG_NUM - 1)) begin
                            state_d     = S_POLL_DLY;
                            init_done_d = 1'b1;
                        end else begin
                            state_d   = S_CFG_ISSUE;
                            cfg_idx_d = cfg_idx + IDX_W'(1);
                        end
                    end else begin
`ifdef PAJ7620_RETRY_EN
                        if (rty_cnt == RTY_W'(RETRY_MAX)) begin
                            state_d   = S_ERR;
                            err_d     = 1'b1;
                            rty_cnt_d = '0;
                        end else begin
                            state_d   = S_CFG_ISSUE;
                            rty_cnt_d = rty_cnt + RTY_W'(1);
                        end
`else
                        state_d = S_ERR;
                        err_d   = 1'b1;
`endif
                    end
                end
            end

            S_POLL_DLY: begin
                if (cnt == CNT_W'(POLL_DLY - 1)) begin
                    state_d     = S_RD_WAIT;
                    i2c_start_d = 1'b1;
                    rd_en_d     = 1'b1;
                    wr_en_d     = 1'b0;
                    byte_addr_d = GES_REG;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            S_RD_WAIT: begin
                if (i2c_end) begin
                    if (!i2c_nack) begin
`ifdef PAJ7620_RETRY_EN
                        rty_cnt_d = '0;
`endif
                        state_d = S_POLL_DLY;
                        if (rd_data != 8'h00) begin
                            gesture_d     = rd_data;
                            gesture_vld_d = 1'b1;
                        end
                    end else begin
`ifdef PAJ7620_RETRY_EN
                        if (rty_cnt == RTY_W'(RETRY_MAX)) begin
                            state_d   = S_ERR;
                            err_d     = 1'b1;
                            rty_cnt_d = '0;
                        end else begin
                            rty_cnt_d   = rty_cnt + RTY_W'(1);
                            i2c_start_d = 1'b1;
                            rd_en_d     = 1'b1;
                            wr_en_d     = 1'b0;
                            byte_addr_d = GES_REG;
                        end
`else
                        state_d = S_ERR;
                        err_d   = 1'b1;
`endif
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cfg_idx     <= '0;
            i2c_start   <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            byte_addr   <= 8'h00;
            wr_data     <= 8'h00;
            init_done   <= 1'b0;
            gesture     <= 8'h00;
            gesture_vld <= 1'b0;
            err         <= 1'b0;
`ifdef PAJ7620_RETRY_EN
            rty_cnt     <= '0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cfg_idx     <= cfg_idx_d;
            i2c_start   <= i2c_start_d;
            wr_en       <= wr_en_d;
            rd_en       <= rd_en_d;
            byte_addr   <= byte_addr_d;
            wr_data     <= wr_data_d;
            init_done   <= init_done_d;
            gesture     <= gesture_d;
            gesture_vld <= gesture_vld_d;
            err         <= err_d;
`ifdef PAJ7620_RETRY_EN
            rty_cnt     <= rty_cnt_d;
`endif
        end
    end

endmodule

// File: doc/paj7620_seq.md
# paj7620_seq

Sequencer for the PAJ7620 gesture sensor. It sits between the configuration-table ROM and the I2C master, both running on `i2c_clk`. After `start` it wakes the sensor, waits out the wake-up delay, and streams the full register table through the I2C master one write at a time. It then polls the gesture-flag register forever and reports each non-zero result.

## Interface
Parameters:
- `CFG_NUM`, 51: number of table entries; indices run 0..CFG_NUM-1, max 64.
- `WAKE_DLY`, 1000: `i2c_clk` cycles to wait after the wake access.
- `POLL_DLY`, 10000: `i2c_clk` cycles between gesture reads.
- `GES_REG`, 8'h43: register address of the gesture flag.
- `RETRY_MAX`, 3: re-issues allowed per transaction; used only with `PAJ7620_RETRY_EN`.

Ports:
- `i2c_clk`, in, 1: the single clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: starts the init sequence; sampled only in IDLE or ERR.
- `i2c_end`, in, 1: one-cycle pulse from the master when a transaction finishes.
- `i2c_nack`, in, 1: NACK status; valid only in the cycle `i2c_end` is high.
- `rd_data`, in, 8: read byte; valid only in the cycle `i2c_end` is high.
- `cfg_data`, in, 16: {reg_addr, reg_data}; combinational lookup of `cfg_idx`.
- `cfg_idx`, out, 6: table index.
- `i2c_start`, out, 1: one-cycle transaction request.
- `wr_en`, out, 1: current transaction is a write.
- `rd_en`, out, 1: current transaction is a read.
- `byte_addr`, out, 8: sensor register address.
- `wr_data`, out, 8: byte to write.
- `init_done`, out, 1: level; high once the table has been written.
- `gesture`, out, 8: last non-zero gesture flag.
- `gesture_vld`, out, 1: one-cycle pulse when `gesture` is updated.
- `err`, out, 1: sticky error flag.

## Operation
States:
- **IDLE**
  - `start`=1 → **WAKE_WAIT**.
  - Issues the wake write: `wr_en`=1, `byte_addr`=0x00, `wr_data`=0x00.
- **WAKE_WAIT**
  - On `i2c_end` → **WAKE_DLY**.
  - `i2c_nack` is ignored here; the sensor NACKs while asleep.
- **WAKE_DLY**
  - Counts WAKE_DLY cycles, then → **CFG_ISSUE** with `cfg_idx`=0.
- **CFG_ISSUE** (1 cycle)
  - Latches `byte_addr`=`cfg_data[15:8]` and `wr_data`=`cfg_data[7:0]`.
  - Sets `wr_en`=1 and `rd_en`=0.
  - → **CFG_WAIT**.
- **CFG_WAIT**, on `i2c_end`:
  - ACK and `cfg_idx`<CFG_NUM-1: `cfg_idx`+1, → **CFG_ISSUE**.
  - ACK and `cfg_idx`=CFG_NUM-1: `init_done`←1, `cfg_idx` holds, → **POLL_DLY**.
  - NACK: see Configuration.
- **POLL_DLY**
  - Counts POLL_DLY cycles.
  - Then issues the read: `rd_en`=1, `wr_en`=0, `byte_addr`=GES_REG; → **RD_WAIT**.
- **RD_WAIT**, on `i2c_end`:
  - ACK: if `rd_data`≠0, then `gesture`←`rd_data` and `gesture_vld`←1 in the following cycle. → **POLL_DLY**.
  - NACK: see Configuration.
- **ERR**
  - `err`=1.
  - `start` → **WAKE_WAIT**: clears `err` and `init_done`, resets `cfg_idx` to 0, reissues the wake.

Every `i2c_start` pulse is registered together with `wr_en`, `rd_en`, `byte_addr` and `wr_data`. Those four signals hold until the next issue.

Boundaries:
- `start` outside IDLE/ERR is ignored.
- `i2c_end` outside the *_WAIT states is ignored.
- Delay counters are sized from `$clog2` of the larger delay and cleared on every state entry.
- A reset in any state, including mid-transaction, returns to IDLE with all outputs 0. No transaction is issued until the next `start`.

## Timing
Reset values: every output is 0, state=IDLE, `cfg_idx`=0.

Latencies:
- `start` sampled at cycle N → `i2c_start` high at N+1.
- `i2c_end` at cycle N in CFG_WAIT → `cfg_idx` updated at N+1 → next `i2c_start` at N+2.
- `i2c_end` at N in WAKE_WAIT → first config `i2c_start` at N+WAKE_DLY+2.
- Read `i2c_end` at N → `gesture_vld` at N+1 → next read `i2c_start` at N+POLL_DLY+1.

## Configuration
`PAJ7620_RETRY_EN`:
- Defined:
  - A NACK in CFG_WAIT re-enters CFG_ISSUE with `cfg_idx` unchanged.
  - A NACK in RD_WAIT re-issues the read immediately.
  - A per-transaction retry counter is cleared on every ACK.
  - The (RETRY_MAX+1)th consecutive NACK → ERR.
- Undefined:
  - The first NACK in CFG_WAIT or RD_WAIT → ERR.
  - No retry counter is synthesized.

## Test plan
Bench parameters: CFG_NUM=4, WAKE_DLY=10, POLL_DLY=20, with a master model that returns `i2c_end` 5 cycles after each `i2c_start`.

1. Reset release, then `start` → wake write to 0x00 with NACK. Then 4 writes matching table entries 0..3, the first at `i2c_end`+12. Then `init_done`=1 and a read of 0x43.
2. Read returns 0x00 then 0x04 → no `gesture_vld` for the first read. One-cycle `gesture_vld` with `gesture`=0x04 after the second. Read spacing is 20+1 cycles plus transaction time.
3. Without the macro, NACK on config entry 2 → `err`=1, state ERR, no further `i2c_start`. `start` → wake reissued, `err`=0, `cfg_idx`=0.
4. With the macro, NACK twice on entry 1 then ACK → entry 1 issued 3 times, then sequence completes. With 4 consecutive NACKs → `err`=1.
5. `sys_rst_n` asserted while in CFG_WAIT → all outputs 0 immediately; a spurious `i2c_end` after release produces no `i2c_start`.
6. `start` pulsed during CFG and POLL, and `i2c_end` pulsed during WAKE_DLY → no state change and no extra `i2c_start`.
